// File: rtl/branch_pkg.sv
// Shared constants and types for the EX-stage branch resolution controller.
package branch_pkg;

    // RV32 control-transfer opcodes
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Conditional branch funct3 encodings (010 and 011 are undefined)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        REDIRECT
    } bctrl_state_t;

    // Weakly not-taken
    localparam logic [1:0] BHT_RESET = 2'b01;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: decides taken/not-taken from funct3 and operands.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rd1 == rd2);
    assign lt_s = ($signed(rd1) < $signed(rd2));
    assign lt_u = (rd1 < rd2);

    // Select the comparison named by funct3; undefined encodings fall through as not-taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the EX stage: resolves branches/jumps, keeps a
// bimodal history table for fetch prediction, and issues a redirect + flush on mispredict.
// Optional build macro BRANCH_CTRL_PERF_EN adds branch/mispredict performance counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_stall,
    input  logic [6:0]      ex_op,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rd1,
    input  logic [XLEN-1:0] ex_rd2,
    input  logic            ex_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush
`ifdef BRANCH_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int unsigned BHT_N = 1 << BHT_IDX_W;

    bctrl_state_t          state;
    logic [1:0]            bht [BHT_N];

    logic                  is_br;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  accept;
    logic                  cmp_taken;
    logic                  taken;
    logic                  mispredict;
    logic [XLEN-1:0]       br_target;
    logic [XLEN-1:0]       jalr_sum;
    logic [XLEN-1:0]       next_pc;
    logic [BHT_IDX_W-1:0]  if_idx;
    logic [BHT_IDX_W-1:0]  ex_idx;
    logic                  unused_pc_bits;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3 (ex_funct3),
        .rd1    (ex_rd1),
        .rd2    (ex_rd2),
        .taken  (cmp_taken)
    );

    assign if_idx         = if_pc[BHT_IDX_W+1:2];
    assign ex_idx         = ex_pc[BHT_IDX_W+1:2];
    assign if_pred_taken  = bht[if_idx][1];
    assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    assign ex_ready = (state == IDLE);

    // Decode, resolve direction and next PC for the instruction in EX
    always_comb begin
        is_br      = (ex_op == OP_BRANCH);
        is_jal     = (ex_op == OP_JAL);
        is_jalr    = (ex_op == OP_JALR);
        accept     = ex_valid & ex_ready & ~ex_stall & (is_br | is_jal | is_jalr);
        taken      = is_jal | is_jalr | (is_br & cmp_taken);
        // Fetch never predicts jumps, so any jump is a mispredict
        mispredict = is_jal | is_jalr | (is_br & (cmp_taken != ex_pred_taken));
        br_target  = ex_pc + ex_imm;
        jalr_sum   = ex_rd1 + ex_imm;
        next_pc    = ex_pc + XLEN'(4);
        if (taken) begin
            next_pc = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
        end
    end

    // Redirect FSM with registered redirect_valid/redirect_pc/flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush <= 1'b0;
                    if (accept && mispredict) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= next_pc;
                        flush          <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // flush pulses only in the first REDIRECT cycle; redirect_pc holds
                    flush <= 1'b0;
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

    // Saturating 2-bit history update on accepted conditional branches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bht <= '{default: BHT_RESET};
        end else if (accept && is_br) begin
            if (cmp_taken) begin
                if (bht[ex_idx] != 2'b11) begin
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
                end
            end else begin
                if (bht[ex_idx] != 2'b00) begin
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
                end
            end
        end
    end

`ifdef BRANCH_CTRL_PERF_EN
    // Free-running wrap-around counters of accepted control transfers and mispredicts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (accept) begin
            perf_branches <= perf_branches + 32'd1;
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_stall;
    logic [6:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    branch_ctrl #(
        .XLEN      (32),
        .BHT_IDX_W (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_stall       (ex_stall),
        .ex_op          (ex_op),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rd1         (ex_rd1),
        .ex_rd2         (ex_rd2),
        .ex_pred_taken  (ex_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush)
`ifdef BRANCH_CTRL_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic pred);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rd1        = rd1;
        ex_rd2        = rd2;
        ex_pred_taken = pred;
    endtask

    task automatic handshake();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
    endtask

    // One conditional branch, called at a negedge; checks redirect and target
    task automatic run_br(input string tag, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic pred,
                          input logic exp_rv, input logic [31:0] exp_pc);
        set_ex(OP_BR, f3, pc, imm, rd1, rd2, pred);
        @(negedge clk);
        ex_valid = 1'b0;
        chk({tag, "_rv"}, 32'(redirect_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk({tag, "_pc"}, redirect_pc, exp_pc);
            handshake();
        end
    endtask

    initial begin
        rstn           = 1'b0;
        if_pc          = 32'h0;
        ex_valid       = 1'b0;
        ex_stall       = 1'b0;
        ex_op          = 7'h0;
        ex_funct3      = 3'h0;
        ex_pc          = 32'h0;
        ex_imm         = 32'h0;
        ex_rd1         = 32'h0;
        ex_rd2         = 32'h0;
        ex_pred_taken  = 1'b0;
        redirect_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        if_pc = 32'h100;
        #1;
        chk("rst_pred", 32'(if_pred_taken), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
`ifdef BRANCH_CTRL_PERF_EN
        chk("rst_perf_br", perf_branches, 32'h0);
        chk("rst_perf_mp", perf_mispredicts, 32'h0);
`endif
        rstn = 1'b1;

        // beq taken, predicted not-taken
        @(negedge clk);
        set_ex(OP_BR, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5, 1'b0);
        if_pc = 32'h40;
        #1 chk("beq_rbw", 32'(if_pred_taken), 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("beq_rv", 32'(redirect_valid), 32'd1);
        chk("beq_rpc", redirect_pc, 32'h60);
        chk("beq_flush", 32'(flush), 32'd1);
        chk("beq_ready", 32'(ex_ready), 32'd0);
        chk("beq_bht", 32'(if_pred_taken), 32'd1);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk("beq_rv_done", 32'(redirect_valid), 32'd0);
        chk("beq_flush_done", 32'(flush), 32'd0);
        chk("beq_ready_done", 32'(ex_ready), 32'd1);

        // bltu not taken (counter 1->0), then blt taken (counter 0->1)
        set_ex(OP_BR, 3'b110, 32'h44, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
        if_pc = 32'h44;
        @(negedge clk);
        chk("bltu_rv", 32'(redirect_valid), 32'd0);
        set_ex(OP_BR, 3'b100, 32'h44, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("blt_rv", 32'(redirect_valid), 32'd1);
        chk("blt_rpc", redirect_pc, 32'h54);
        chk("bltu_bht_dec", 32'(if_pred_taken), 32'd0);
        handshake();

        // Non-branch opcode is ignored
        set_ex(7'h33, 3'b000, 32'h44, 32'h10, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("alu_rv", 32'(redirect_valid), 32'd0);
        chk("alu_ready", 32'(ex_ready), 32'd1);

        // Stall blocks acceptance and BHT update; negative imm wraps target below pc
        set_ex(OP_BR, 3'b000, 32'h48, 32'hFFFF_FFF8, 32'd7, 32'd7, 1'b0);
        ex_stall = 1'b1;
        if_pc    = 32'h48;
        @(negedge clk);
        chk("stall_rv", 32'(redirect_valid), 32'd0);
        chk("stall_bht", 32'(if_pred_taken), 32'd0);
        ex_stall = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("unstall_rv", 32'(redirect_valid), 32'd1);
        chk("unstall_rpc", redirect_pc, 32'h40);
        handshake();

        // Comparator rules table
        run_br("bne_t", 3'b001, 32'h60, 32'h10, 32'd5, 32'd6, 1'b0, 1'b1, 32'h70);
        run_br("bne_nt", 3'b001, 32'h6C, 32'h10, 32'd4, 32'd4, 1'b0, 1'b0, 32'h0);
        run_br("bge_s", 3'b101, 32'h64, 32'h20, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h84);
        run_br("bgeu_u", 3'b111, 32'h68, 32'h20, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h6C);
        run_br("f3_010", 3'b010, 32'h58, 32'h20, 32'd3, 32'd3, 1'b1, 1'b1, 32'h5C);

        // jalr with fetch stalling the redirect; a jal waits behind it
        set_ex(OP_JALR, 3'b000, 32'h200, 32'h4, 32'h1001, 32'h0, 1'b0);
        if_pc = 32'h200;
        @(negedge clk);
        set_ex(OP_JAL, 3'b000, 32'h300, 32'h100, 32'h0, 32'h0, 1'b0);
        chk("jalr_rv1", 32'(redirect_valid), 32'd1);
        chk("jalr_rpc1", redirect_pc, 32'h1004);
        chk("jalr_flush1", 32'(flush), 32'd1);
        chk("jalr_ready1", 32'(ex_ready), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("jalr_rv%0d", c), 32'(redirect_valid), 32'd1);
            chk($sformatf("jalr_rpc%0d", c), redirect_pc, 32'h1004);
            chk($sformatf("jalr_flush%0d", c), 32'(flush), 32'd0);
            chk($sformatf("jalr_ready%0d", c), 32'(ex_ready), 32'd0);
        end
        chk("jalr_no_bht", 32'(if_pred_taken), 32'd1);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk("jalr_done_rv", 32'(redirect_valid), 32'd0);
        chk("jalr_done_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("jal_rv", 32'(redirect_valid), 32'd1);
        chk("jal_rpc", redirect_pc, 32'h400);
        chk("jal_flush", 32'(flush), 32'd1);
        handshake();

        // Saturation: four correctly-predicted taken branches, then a not-taken one
        if_pc = 32'h4C;
        for (int k = 0; k < 4; k++) begin
            set_ex(OP_BR, 3'b000, 32'h4C, 32'h8, 32'd9, 32'd9, 1'b1);
            @(negedge clk);
            chk($sformatf("sat_rv%0d", k), 32'(redirect_valid), 32'd0);
        end
        ex_valid = 1'b0;
        chk("sat_pred", 32'(if_pred_taken), 32'd1);
        set_ex(OP_BR, 3'b000, 32'h4C, 32'h8, 32'd1, 32'd2, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("sat_nt_rv", 32'(redirect_valid), 32'd1);
        chk("sat_nt_rpc", redirect_pc, 32'h50);
        chk("sat_nt_pred", 32'(if_pred_taken), 32'd1);
        handshake();
        set_ex(OP_BR, 3'b000, 32'h4C, 32'h8, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("sat_nt2_rv", 32'(redirect_valid), 32'd0);
        chk("sat_nt2_pred", 32'(if_pred_taken), 32'd0);

        // Asynchronous reset while in REDIRECT
        set_ex(OP_JAL, 3'b000, 32'h80, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("prerst_rv", 32'(redirect_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_rv", 32'(redirect_valid), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_rpc", redirect_pc, 32'h0);
        chk("arst_ready", 32'(ex_ready), 32'd1);
        if_pc = 32'h40;
        #1 chk("arst_bht", 32'(if_pred_taken), 32'd0);
`ifdef BRANCH_CTRL_PERF_EN
        chk("arst_perf_br", perf_branches, 32'h0);
        chk("arst_perf_mp", perf_mispredicts, 32'h0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
